wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Parametrised wash-cycle controller for the washer control path. It runs a selectable program as a sequence of timed phases: fill, wash, drain, rinse, rinse-drain and spin. Wash and rinse repeat counts and phase lengths are set by parameters. The block adds pause/resume, abort-with-drain, power-loss handling and a live remaining-time countdown. It drives the water valves, the motor, the door lock and the status display directly.

## Interface
- `TW`, 8: phase-counter width; every `*_T` must be between 1 and 2^TW−1.
- `RW`, 12: width of `remaining`; the largest program total must fit in RW bits.
- `FILL_T`, 4: fill phase length in cycles.
- `WASH_T`, 6: wash agitation length in cycles.
- `DRAIN_T`, 3: drain length in cycles; used for wash drain, rinse drain and abort drain.
- `RINSE_T`, 4: rinse (cold fill plus agitate) length in cycles.
- `SPIN_T`, 6: final spin length in cycles.
- `WASH_CYCLES`, 2: number of fill/wash/drain repeats; must be ≥1.
- `RINSE_CYCLES`, 2: number of rinse/rinse-drain repeats; must be ≥1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `power`  in  1  mains present; low forces IDLE.
- `start`  in  1  start in IDLE; resume in PAUSE.
- `pause`  in  1  pause request.
- `abort`  in  1  cancel the running program.
- `doorclosed`  in  1  door sensor.
- `soap`  in  1  detergent present.
- `program_sel`  in  3  0 cold, 1 hot, 2 warm, 3 rinse+spin, 4 spin-only; 5–7 invalid.
- `valve_cold`, `valve_hot`, `valve_out`  out  1 each  water valves.
- `motor`  out  2  0 off, 1 wash, 2 spin.
- `soap_in`, `soap_warning`, `door_lock`, `busy`  out  1 each  status outputs.
- `done`  out  1  one-cycle pulse on normal completion.
- `phase`  out  4  current state code.
- `remaining`  out  RW  cycles left in the program.

## Operation
- State codes: IDLE 0, FILL 1, WASH 2, DRAIN 3, RINSE 4, RDRAIN 5, SPIN 6, SOAP_WAIT 7, PAUSE 8, ABORT 9, DONE 10.
- Active phases are FILL, WASH, DRAIN, RINSE, RDRAIN, SPIN and ABORT.
- All outputs are registered. Reset value of every output is 0 (phase = IDLE).
- Start condition: in IDLE, power&start&doorclosed with program_sel ≤4.
  - `program_sel` is latched on the start cycle. Later changes are ignored until the block returns to IDLE.
  - An invalid program keeps the block in IDLE.
- Program sequences:
  - Wash programs 0–2: (FILL→WASH→DRAIN) × WASH_CYCLES, then (RINSE→RDRAIN) × RINSE_CYCLES, then SPIN→DONE→IDLE.
  - Program 3: starts at RINSE and follows the same rinse/spin tail.
  - Program 4: SPIN→DONE→IDLE.
- Phase counter: loaded with the phase length on entry and decremented each cycle. The phase exits when the counter reads 1, so each phase lasts exactly its `*_T` cycles.
- Per-state outputs:
  - FILL: `soap_in`=1. Valves by program: cold → `valve_cold`; hot → `valve_hot`; warm → both.
  - WASH: `motor`=1.
  - RINSE: `valve_cold`=1 and `motor`=1.
  - DRAIN, RDRAIN and ABORT: `valve_out`=1.
  - SPIN: `motor`=2 and `valve_out`=1.
  - SOAP_WAIT: `soap_warning`=1.
  - PAUSE and DONE: everything off.
- Soap: in FILL with `soap`=0, go to SOAP_WAIT with the counter held. Return to FILL, resuming the held count, on the first cycle `soap`=1.
- Pause: `pause`=1 in any active phase except ABORT goes to PAUSE. The return state and counter are held. `start`&`doorclosed` resumes into the held state.
- Abort: `abort`=1 in any non-IDLE state except ABORT enters ABORT for DRAIN_T cycles, then IDLE.
  - `remaining` is forced to 0 on abort entry.
  - `done` is not pulsed.
- Power loss: `power`=0 in any state goes to IDLE on the next edge, with all outputs and counters cleared.
- Priority when inputs coincide: power-off > abort > pause > soap > phase expiry.
- `door_lock` = `busy` = 1 in every state except IDLE, PAUSE and DONE.
- Remaining time:
  - Loaded on the start cycle with the program total:
    - Wash programs: WASH_CYCLES·(FILL_T+WASH_T+DRAIN_T) + RINSE_CYCLES·(RINSE_T+DRAIN_T) + SPIN_T.
    - Program 3: RINSE_CYCLES·(RINSE_T+DRAIN_T) + SPIN_T.
    - Program 4: SPIN_T.
  - Decrements by 1 each cycle in a non-ABORT active phase.
  - Held in SOAP_WAIT and PAUSE.
  - Reads 0 in DONE and never underflows.
- Repeat counters for wash and rinse repeats: cleared on start and advanced on each DRAIN / RDRAIN exit.

## Timing
- Start sampled at edge 0 → first phase entered at edge 1; outputs are valid in the cycle after the edge.
- Normal completion: DONE is entered on the cycle after the final SPIN cycle.
  - `done`=1 for exactly 1 cycle; IDLE follows on the next cycle.
- Pause, abort, soap-wait and power-off each take effect on the edge after the input is sampled high (or low, for soap and power).
- Resume from PAUSE takes effect one cycle after `start` is sampled.
- No combinational input-to-output paths.

## Test plan
- Defaults, program 0, start at cycle 0 → FILL at cycle 1 with `valve_cold`=1; `remaining`=46 at cycle 1; `done` pulses at cycle 47; `remaining`=0 at DONE.
- Program 2, `soap`=0 for cycles 1–5 → SOAP_WAIT with `soap_warning`=1 and `remaining` frozen at 46; resumes with `valve_hot`=`valve_cold`=1; `done` at cycle 52.
- Program 4 → SPIN with `motor`=2 and `valve_out`=1 for 6 cycles; `done` at cycle 7; `door_lock` drops with DONE.
- `pause` during WASH, resume with `start` 10 cycles later → counter and `remaining` held; total delay of exactly 10 cycles plus resume latency; `door_lock`=0 while paused.
- `abort` during RINSE → ABORT with `valve_out`=1 for 3 cycles, then IDLE; `done` never pulses; `remaining`=0.
- Program 5 or `doorclosed`=0 on start → stays IDLE; `power` drop mid-SPIN → IDLE with all outputs 0 on the next cycle; `rst` mid-run → immediate IDLE.

Source files
------------

// File: rtl/wash_sequencer.sv
// wash_sequencer: timed wash-cycle controller.
// Runs a selected program as a sequence of timed phases. It supports
// soap wait, pause/resume, abort-with-drain and power loss, and it keeps
// a live count of the cycles left in the program.
// Ports:
//   clk, rst (async, active-high)
//   power, start, pause, abort, doorclosed, soap, program_sel[2:0] - controls/sensors
//   valve_cold, valve_hot, valve_out, motor[1:0]       - actuators
//   soap_in, soap_warning, door_lock, busy, done       - status
//   phase[3:0] (state code), remaining[RW-1:0]          - display
// All outputs are registered.
module wash_sequencer #(
   parameter int TW           = 8,
   parameter int RW           = 12,
   parameter int FILL_T       = 4,
   parameter int WASH_T       = 6,
   parameter int DRAIN_T      = 3,
   parameter int RINSE_T      = 4,
   parameter int SPIN_T       = 6,
   parameter int WASH_CYCLES  = 2,
   parameter int RINSE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          power,
   input  logic          start,
   input  logic          pause,
   input  logic          abort,
   input  logic          doorclosed,
   input  logic          soap,
   input  logic [2:0]    program_sel,
   output logic          valve_cold,
   output logic          valve_hot,
   output logic          valve_out,
   output logic [1:0]    motor,
   output logic          soap_in,
   output logic          soap_warning,
   output logic          door_lock,
   output logic          busy,
   output logic          done,
   output logic [3:0]    phase,
   output logic [RW-1:0] remaining
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FILL  = 4'd1, S_WASH = 4'd2, S_DRAIN = 4'd3,
      S_RINSE  = 4'd4,  S_RDRAIN = 4'd5, S_SPIN = 4'd6, S_SOAP_WAIT = 4'd7,
      S_PAUSE  = 4'd8,  S_ABORT = 4'd9, S_DONE = 4'd10
   } state_t;

   localparam int TOTAL_RINSE = RINSE_CYCLES * (RINSE_T + DRAIN_T) + SPIN_T;
   localparam int TOTAL_WASH  = WASH_CYCLES * (FILL_T + WASH_T + DRAIN_T) + TOTAL_RINSE;
   localparam int WREPW = $clog2(WASH_CYCLES + 1);
   localparam int RREPW = $clog2(RINSE_CYCLES + 1);
   localparam logic [WREPW-1:0] WASH_LAST  = WREPW'(WASH_CYCLES - 1);
   localparam logic [RREPW-1:0] RINSE_LAST = RREPW'(RINSE_CYCLES - 1);

   state_t            state, state_next, ret_state, ret_next;
   logic [TW-1:0]     cnt, cnt_next;
   logic [RW-1:0]     rem_next;
   logic [WREPW-1:0]  wash_rep, wash_rep_next;
   logic [RREPW-1:0]  rinse_rep, rinse_rep_next;
   logic [2:0]        prog, prog_next;
   logic              running, cnt_last;
   logic              valve_cold_next, valve_hot_next, valve_out_next;
   logic [1:0]        motor_next;
   logic              soap_in_next, soap_warning_next, busy_next, done_next;

   // Phases that count down and may be paused (ABORT counts but cannot pause).
   assign running  = state inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_RDRAIN, S_SPIN};
   assign cnt_last = (cnt == TW'(1));

   always_comb begin
      state_next     = state;
      ret_next       = ret_state;
      cnt_next       = cnt;
      rem_next       = remaining;
      wash_rep_next  = wash_rep;
      rinse_rep_next = rinse_rep;
      prog_next      = prog;

      if (!power) begin
         state_next     = S_IDLE;
         ret_next       = S_IDLE;
         cnt_next       = '0;
         rem_next       = '0;
         wash_rep_next  = '0;
         rinse_rep_next = '0;
         prog_next      = '0;
      end else if (state == S_IDLE) begin
         if (start && doorclosed && (program_sel <= 3'd4)) begin
            prog_next      = program_sel;
            wash_rep_next  = '0;
            rinse_rep_next = '0;
            if (program_sel == 3'd4) begin
               state_next = S_SPIN;
               cnt_next   = TW'(SPIN_T);
               rem_next   = RW'(SPIN_T);
            end else if (program_sel == 3'd3) begin
               state_next = S_RINSE;
               cnt_next   = TW'(RINSE_T);
               rem_next   = RW'(TOTAL_RINSE);
            end else begin
               state_next = S_FILL;
               cnt_next   = TW'(FILL_T);
               rem_next   = RW'(TOTAL_WASH);
            end
         end
      end else if (abort && state != S_ABORT) begin
         state_next = S_ABORT;
         cnt_next   = TW'(DRAIN_T);
         rem_next   = '0;
      end else if (pause && running) begin
         // Counter and remaining stay frozen; ret_state remembers where to resume.
         state_next = S_PAUSE;
         ret_next   = state;
      end else if (state == S_FILL && !soap) begin
         state_next = S_SOAP_WAIT;
      end else begin
         case (state)
            S_FILL, S_WASH, S_DRAIN, S_RINSE, S_RDRAIN, S_SPIN: begin
               if (remaining != '0) rem_next = remaining - RW'(1);
               if (!cnt_last) begin
                  cnt_next = cnt - TW'(1);
               end else begin
                  case (state)
                     S_FILL: begin
                        state_next = S_WASH;
                        cnt_next   = TW'(WASH_T);
                     end
                     S_WASH: begin
                        state_next = S_DRAIN;
                        cnt_next   = TW'(DRAIN_T);
                     end
                     S_DRAIN: begin
                        wash_rep_next = wash_rep + WREPW'(1);
                        if (wash_rep == WASH_LAST) begin
                           state_next = S_RINSE;
                           cnt_next   = TW'(RINSE_T);
                        end else begin
                           state_next = S_FILL;
                           cnt_next   = TW'(FILL_T);
                        end
                     end
                     S_RINSE: begin
                        state_next = S_RDRAIN;
                        cnt_next   = TW'(DRAIN_T);
                     end
                     S_RDRAIN: begin
                        rinse_rep_next = rinse_rep + RREPW'(1);
                        if (rinse_rep == RINSE_LAST) begin
                           state_next = S_SPIN;
                           cnt_next   = TW'(SPIN_T);
                        end else begin
                           state_next = S_RINSE;
                           cnt_next   = TW'(RINSE_T);
                        end
                     end
                     default: begin
                        state_next = S_DONE;
                        cnt_next   = '0;
                        rem_next   = '0;
                     end
                  endcase
               end
            end
            S_ABORT: begin
               if (cnt_last) begin
                  state_next = S_IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt - TW'(1);
               end
            end
            S_SOAP_WAIT: if (soap) state_next = S_FILL;
            S_PAUSE:     if (start && doorclosed) state_next = ret_state;
            S_DONE: begin
               state_next = S_IDLE;
               rem_next   = '0;
            end
            default: state_next = S_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they register alongside it.
      valve_cold_next   = (state_next == S_FILL && (prog_next == 3'd0 || prog_next == 3'd2))
                          || state_next == S_RINSE;
      valve_hot_next    = state_next == S_FILL && (prog_next == 3'd1 || prog_next == 3'd2);
      valve_out_next    = state_next inside {S_DRAIN, S_RDRAIN, S_ABORT, S_SPIN};
      motor_next        = (state_next == S_SPIN) ? 2'd2 :
                          (state_next == S_WASH || state_next == S_RINSE) ? 2'd1 : 2'd0;
      soap_in_next      = state_next == S_FILL;
      soap_warning_next = state_next == S_SOAP_WAIT;
      busy_next         = !(state_next inside {S_IDLE, S_PAUSE, S_DONE});
      done_next         = state_next == S_DONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ret_state    <= S_IDLE;
         cnt          <= '0;
         remaining    <= '0;
         wash_rep     <= '0;
         rinse_rep    <= '0;
         prog         <= '0;
         valve_cold   <= 1'b0;
         valve_hot    <= 1'b0;
         valve_out    <= 1'b0;
         motor        <= 2'd0;
         soap_in      <= 1'b0;
         soap_warning <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_next;
         ret_state    <= ret_next;
         cnt          <= cnt_next;
         remaining    <= rem_next;
         wash_rep     <= wash_rep_next;
         rinse_rep    <= rinse_rep_next;
         prog         <= prog_next;
         valve_cold   <= valve_cold_next;
         valve_hot    <= valve_hot_next;
         valve_out    <= valve_out_next;
         motor        <= motor_next;
         soap_in      <= soap_in_next;
         soap_warning <= soap_warning_next;
         busy         <= busy_next;
         done         <= done_next;
      end
   end

   assign door_lock = busy;
   assign phase     = state;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed testbench for wash_sequencer (default parameters).
// Cycle numbering: the edge that samples start produces cycle 1; inputs
// set during cycle c are sampled by the edge that produces cycle c+1.
module tb_wash_sequencer;
   logic        clk = 1'b0;
   logic        rst, power, start, pause, abort, doorclosed, soap;
   logic [2:0]  program_sel;
   logic        valve_cold, valve_hot, valve_out, soap_in, soap_warning, door_lock, busy, done;
   logic [1:0]  motor;
   logic [3:0]  phase;
   logic [11:0] remaining;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   wash_sequencer dut (
      .clk(clk), .rst(rst), .power(power), .start(start), .pause(pause), .abort(abort),
      .doorclosed(doorclosed), .soap(soap), .program_sel(program_sel),
      .valve_cold(valve_cold), .valve_hot(valve_hot), .valve_out(valve_out), .motor(motor),
      .soap_in(soap_in), .soap_warning(soap_warning), .door_lock(door_lock), .busy(busy),
      .done(done), .phase(phase), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle_inputs();
      power = 1; start = 0; pause = 0; abort = 0; doorclosed = 1; soap = 1; program_sel = 3'd0;
   endtask

   task automatic do_start(input logic [2:0] sel);
      program_sel = sel;
      start = 1;
      cyc = 0;
      tick();
      start = 0;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // Steps until done is seen (bounded); at is the cycle or -1 on timeout.
   task automatic run_to_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit && at < 0; i++) begin
         if (done) at = cyc;
         else tick();
      end
   endtask

   function automatic logic [9:0] outs();
      return {valve_cold, valve_hot, valve_out, motor, soap_in, soap_warning, door_lock, busy, done};
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (phase !== 4'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
      checks++; if (outs() !== 10'd0) begin errors++; $display("FAIL reset_outs got %b want 0", outs()); end
      checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL reset_remaining got %0d want 0", remaining); end
      @(negedge clk) rst = 0;
      $display("test_reset complete");
   endtask

   task automatic test_program0();
      int at;
      idle_inputs();
      do_start(3'd0);
      program_sel = 3'd1;  // must be ignored: program was latched at start
      checks++; if (phase !== 4'd1) begin errors++; $display("FAIL p0_fill_phase got %0d want 1", phase); end
      checks++; if ({valve_cold, valve_hot, soap_in} !== 3'b101) begin errors++; $display("FAIL p0_fill_valves got %b want 101", {valve_cold, valve_hot, soap_in}); end
      checks++; if (remaining !== 12'd46) begin errors++; $display("FAIL p0_remaining_c1 got %0d want 46", remaining); end
      checks++; if (door_lock !== 1'b1) begin errors++; $display("FAIL p0_door_lock got %b want 1", door_lock); end
      run_to(5);
      checks++; if ({phase, motor, remaining} !== {4'd2, 2'd1, 12'd42}) begin errors++; $display("FAIL p0_wash_c5 got ph=%0d m=%0d rem=%0d want ph=2 m=1 rem=42", phase, motor, remaining); end
      run_to(14);
      checks++; if ({phase, valve_cold, valve_hot} !== {4'd1, 2'b10}) begin errors++; $display("FAIL p0_second_fill got ph=%0d c=%b h=%b want ph=1 c=1 h=0", phase, valve_cold, valve_hot); end
      run_to_done(60, at);
      checks++; if (at !== 47) begin errors++; $display("FAIL p0_done_cycle got %0d want 47", at); end
      checks++; if ({phase, remaining, door_lock} !== {4'd10, 12'd0, 1'b0}) begin errors++; $display("FAIL p0_done_state got ph=%0d rem=%0d lock=%b want ph=10 rem=0 lock=0", phase, remaining, door_lock); end
      tick();
      checks++; if ({phase, done} !== {4'd0, 1'b0}) begin errors++; $display("FAIL p0_after_done got ph=%0d done=%b want ph=0 done=0", phase, done); end
      $display("test_program0 done_at=%0d", at);
   endtask

   task automatic test_soap_wait();
      int at;
      idle_inputs();
      soap = 0;
      do_start(3'd2);
      checks++; if ({phase, valve_cold, valve_hot, remaining} !== {4'd1, 2'b11, 12'd46}) begin errors++; $display("FAIL sw_fill_c1 got ph=%0d c=%b h=%b rem=%0d want ph=1 c=1 h=1 rem=46", phase, valve_cold, valve_hot, remaining); end
      tick();
      checks++; if ({phase, soap_warning, soap_in, valve_cold, valve_hot} !== {4'd7, 4'b1000}) begin errors++; $display("FAIL sw_wait_c2 got ph=%0d warn=%b sin=%b c=%b h=%b want ph=7 warn=1 rest 0", phase, soap_warning, soap_in, valve_cold, valve_hot); end
      run_to(5);
      checks++; if ({phase, remaining} !== {4'd7, 12'd46}) begin errors++; $display("FAIL sw_wait_c5 got ph=%0d rem=%0d want ph=7 rem=46", phase, remaining); end
      soap = 1;
      tick();
      checks++; if ({phase, valve_cold, valve_hot, soap_warning, remaining} !== {4'd1, 3'b110, 12'd46}) begin errors++; $display("FAIL sw_resume_c6 got ph=%0d c=%b h=%b warn=%b rem=%0d want ph=1 c=1 h=1 warn=0 rem=46", phase, valve_cold, valve_hot, soap_warning, remaining); end
      run_to_done(60, at);
      checks++; if (at !== 52) begin errors++; $display("FAIL sw_done_cycle got %0d want 52", at); end
      tick();
      $display("test_soap_wait done_at=%0d", at);
   endtask

   task automatic test_spin_only();
      int at;
      idle_inputs();
      do_start(3'd4);
      checks++; if ({phase, motor, valve_out, remaining} !== {4'd6, 2'd2, 1'b1, 12'd6}) begin errors++; $display("FAIL spin_c1 got ph=%0d m=%0d out=%b rem=%0d want ph=6 m=2 out=1 rem=6", phase, motor, valve_out, remaining); end
      run_to(6);
      checks++; if ({phase, motor, remaining} !== {4'd6, 2'd2, 12'd1}) begin errors++; $display("FAIL spin_c6 got ph=%0d m=%0d rem=%0d want ph=6 m=2 rem=1", phase, motor, remaining); end
      run_to_done(20, at);
      checks++; if (at !== 7) begin errors++; $display("FAIL spin_done_cycle got %0d want 7", at); end
      checks++; if ({door_lock, busy, motor} !== 4'b0000) begin errors++; $display("FAIL spin_done_lock got lock=%b busy=%b m=%0d want 0 0 0", door_lock, busy, motor); end
      tick();
      checks++; if ({phase, done} !== {4'd0, 1'b0}) begin errors++; $display("FAIL spin_idle got ph=%0d done=%b want 0 0", phase, done); end
      $display("test_spin_only done_at=%0d", at);
   endtask

   task automatic test_program3();
      int at;
      idle_inputs();
      do_start(3'd3);
      checks++; if ({phase, valve_cold, motor, remaining} !== {4'd4, 1'b1, 2'd1, 12'd20}) begin errors++; $display("FAIL p3_c1 got ph=%0d c=%b m=%0d rem=%0d want ph=4 c=1 m=1 rem=20", phase, valve_cold, motor, remaining); end
      run_to_done(40, at);
      checks++; if (at !== 21) begin errors++; $display("FAIL p3_done_cycle got %0d want 21", at); end
      tick();
      $display("test_program3 done_at=%0d", at);
   endtask

   task automatic test_pause();
      int at;
      idle_inputs();
      do_start(3'd0);
      run_to(6);
      checks++; if (phase !== 4'd2) begin errors++; $display("FAIL pz_wash_c6 got %0d want 2", phase); end
      pause = 1;
      tick();
      pause = 0;
      checks++; if ({phase, door_lock, busy, motor, remaining} !== {4'd8, 4'b0000, 12'd41}) begin errors++; $display("FAIL pz_paused_c7 got ph=%0d lock=%b busy=%b m=%0d rem=%0d want ph=8 0 0 0 rem=41", phase, door_lock, busy, motor, remaining); end
      run_to(16);
      checks++; if ({phase, remaining} !== {4'd8, 12'd41}) begin errors++; $display("FAIL pz_paused_c16 got ph=%0d rem=%0d want ph=8 rem=41", phase, remaining); end
      start = 1;
      tick();
      start = 0;
      checks++; if ({phase, motor, remaining, door_lock} !== {4'd2, 2'd1, 12'd41, 1'b1}) begin errors++; $display("FAIL pz_resume_c17 got ph=%0d m=%0d rem=%0d lock=%b want ph=2 m=1 rem=41 lock=1", phase, motor, remaining, door_lock); end
      run_to(21);
      checks++; if (phase !== 4'd2) begin errors++; $display("FAIL pz_wash_c21 got %0d want 2", phase); end
      tick();
      checks++; if (phase !== 4'd3) begin errors++; $display("FAIL pz_drain_c22 got %0d want 3", phase); end
      run_to_done(60, at);
      checks++; if (at !== 58) begin errors++; $display("FAIL pz_done_cycle got %0d want 58", at); end
      tick();
      $display("test_pause done_at=%0d", at);
   endtask

   task automatic test_abort();
      int seen = 0;
      idle_inputs();
      do_start(3'd0);
      while (cyc < 28) begin tick(); if (done) seen++; end
      checks++; if (phase !== 4'd4) begin errors++; $display("FAIL ab_rinse_c28 got %0d want 4", phase); end
      abort = 1;
      tick();
      abort = 0;
      checks++; if ({phase, valve_out, valve_cold, motor, remaining} !== {4'd9, 4'b1000, 12'd0}) begin errors++; $display("FAIL ab_enter_c29 got ph=%0d out=%b c=%b m=%0d rem=%0d want ph=9 out=1 c=0 m=0 rem=0", phase, valve_out, valve_cold, motor, remaining); end
      while (cyc < 31) begin tick(); if (done) seen++; end
      checks++; if ({phase, valve_out} !== {4'd9, 1'b1}) begin errors++; $display("FAIL ab_c31 got ph=%0d out=%b want ph=9 out=1", phase, valve_out); end
      tick();
      if (done) seen++;
      checks++; if ({phase, door_lock, valve_out} !== {4'd0, 2'b00}) begin errors++; $display("FAIL ab_idle_c32 got ph=%0d lock=%b out=%b want 0 0 0", phase, door_lock, valve_out); end
      repeat (3) begin tick(); if (done) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL ab_no_done got %0d pulses want 0", seen); end
      $display("test_abort done_pulses=%0d", seen);
   endtask

   task automatic test_invalid_start();
      idle_inputs();
      do_start(3'd5);
      checks++; if ({phase, busy} !== {4'd0, 1'b0}) begin errors++; $display("FAIL inv_prog5 got ph=%0d busy=%b want 0 0", phase, busy); end
      doorclosed = 0;
      do_start(3'd0);
      checks++; if ({phase, busy} !== {4'd0, 1'b0}) begin errors++; $display("FAIL inv_door_open got ph=%0d busy=%b want 0 0", phase, busy); end
      doorclosed = 1;
      do_start(3'd1);
      checks++; if ({phase, valve_hot, valve_cold} !== {4'd1, 2'b10}) begin errors++; $display("FAIL inv_hot_fill got ph=%0d h=%b c=%b want ph=1 h=1 c=0", phase, valve_hot, valve_cold); end
      power = 0;
      tick();
      power = 1;
      $display("test_invalid_start complete");
   endtask

   task automatic test_power_loss();
      idle_inputs();
      do_start(3'd4);
      run_to(3);
      checks++; if (phase !== 4'd6) begin errors++; $display("FAIL pw_spin_c3 got %0d want 6", phase); end
      power = 0;
      tick();
      checks++; if ({phase, outs(), remaining} !== 26'd0) begin errors++; $display("FAIL pw_off_c4 got ph=%0d outs=%b rem=%0d want all 0", phase, outs(), remaining); end
      power = 1;
      tick();
      checks++; if (phase !== 4'd0) begin errors++; $display("FAIL pw_stays_idle got %0d want 0", phase); end
      $display("test_power_loss complete");
   endtask

   task automatic test_reset_midrun();
      idle_inputs();
      do_start(3'd0);
      run_to(5);
      #1 rst = 1;
      #1;
      checks++; if ({phase, outs(), remaining} !== 26'd0) begin errors++; $display("FAIL rst_async got ph=%0d outs=%b rem=%0d want all 0", phase, outs(), remaining); end
      @(negedge clk) rst = 0;
      tick();
      checks++; if (phase !== 4'd0) begin errors++; $display("FAIL rst_after got %0d want 0", phase); end
      $display("test_reset_midrun complete");
   endtask

   initial begin
      test_reset();
      test_program0();
      test_soap_wait();
      test_spin_only();
      test_program3();
      test_pause();
      test_abort();
      test_invalid_start();
      test_power_loss();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
